mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters: DEPTH, default 4, store-buffer entries (power of 2); AW, default 10, address width; DW, default 64, data width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_adr  input  AW  request address.
REQ-008 req_data  input  DW  store data; ignored for loads.
REQ-009 resp_valid  output  1  load data valid, one-cycle pulse.
REQ-010 resp_data  output  DW  load result.
REQ-011 mem_rd  output  1  read strobe to data memory.
REQ-012 mem_read_adr  output  AW  memory read address.
REQ-013 mem_wr  output  1  write strobe to data memory.
REQ-014 mem_write_adr  output  AW  memory write address.
REQ-015 mem_data_in  output  DW  memory write data.
REQ-016 mem_data_out  input  DW  memory read data, combinational from mem_read_adr when mem_rd=1.
REQ-017 sb_count  output  $clog2(DEPTH)+1  current store-buffer occupancy.
REQ-018 idle  output  1  high when store buffer empty and no response pending.

Function
REQ-019 Store buffer: circular FIFO, DEPTH entries of {adr, data}; head/tail pointers wrap modulo DEPTH.
REQ-020 req_ready = (sb_count < DEPTH); applies to loads and stores alike; combinational from registered count only.
REQ-021 Accepted store: enqueued at tail on that edge; no response generated.
REQ-022 Drain: each cycle buffer non-empty and rst=0 -> mem_wr=1, mem_write_adr/mem_data_in = head entry; head pops at edge. Empty -> mem_wr=0, mem_write_adr/mem_data_in = 0.
REQ-023 Store accept and drain in same cycle: sb_count unchanged; the entry accepted is not drained in its accept cycle.
REQ-024 Accepted load, cycle T: compare req_adr against all valid entries including the head being drained in T.
REQ-025 Match: forward data of youngest matching entry; mem_rd=0 in T.
REQ-026 No match: mem_rd=1, mem_read_adr=req_adr in T; mem_data_out captured at end of T.
REQ-027 Either case: resp_valid=1 and resp_data=result in T+1 only; load latency exactly 1 cycle; back-to-back loads give back-to-back responses.
REQ-028 mem_rd=1 and mem_wr=1 with mem_read_adr == mem_write_adr SHALL never occur (follows from REQ-024/025).
REQ-029 mem_rd=0 and mem_read_adr=0 when no load accepted.
REQ-030 resp_data holds its last value while resp_valid=0.
REQ-031 Memory sees stores in acceptance order; a store is never written twice or dropped (except by reset).
REQ-032 idle = (sb_count==0) && !resp_valid.

Reset
REQ-033 rst=1 at edge: head=tail=0, sb_count=0, resp_valid=0, resp_data=0; all buffer entries invalidated.
REQ-034 While rst=1: mem_rd=0, mem_wr=0, req_ready=0; requests presented are not accepted.
REQ-035 Reset mid-operation: undrained stores discarded, never written; a load accepted in the cycle before reset produces no response.
REQ-036 First request accepted in the first cycle with rst=0.

Verification
REQ-037 Store 0xAA@5, idle 3 cycles -> mem_wr=1, mem_write_adr=5, mem_data_in=0xAA exactly one cycle after accept; sb_count 1 -> 0; idle=1 afterwards.
REQ-038 Preload mem[7]=0x1234; load @7 with empty buffer -> mem_rd=1, mem_read_adr=7 in T; resp_valid=1, resp_data=0x1234 in T+1 only.
REQ-039 Stores 0x11@3 then 0x22@3, load @3 next cycle -> mem_rd=0, resp_data=0x22 (youngest); mem later holds 0x22.
REQ-040 Hold mem_wr low via stalled drain impossible, so issue 5 stores on consecutive cycles -> all 5 accepted (drain keeps count <= 4), memory written in order; with DEPTH=1 build, req_ready drops to 0 after first store then returns.
REQ-041 Store @9 then load @9 in cycle the store is at head draining -> forwarded data returned, mem_rd=0; assertion REQ-028 holds across random 10k-request run against reference memory model.
REQ-042 Three stores accepted, rst asserted one cycle -> sb_count=0, no further mem_wr, resp_valid=0; memory unchanged for undrained addresses.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front end with a circular store buffer.
// Stores are queued and drained to data memory one per cycle, oldest first.
// Loads are forwarded from the youngest matching buffered store, otherwise
// read from memory. Either way the response appears exactly one cycle later.
//
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   req_valid/req_ready/req_we         request handshake and type (1 = store)
//   req_adr/req_data                   request address and store data
//   resp_valid/resp_data               one-cycle load response, data held after
//   mem_rd/mem_read_adr/mem_data_out   memory read port (data is combinational)
//   mem_wr/mem_write_adr/mem_data_in   memory write port
//   sb_count                           store-buffer occupancy
//   idle                               buffer empty and no response pending
module mem_access_unit #(
    parameter int DEPTH = 4,
    parameter int AW    = 10,
    parameter int DW    = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [AW-1:0]              req_adr,
    input  logic [DW-1:0]              req_data,
    output logic                       resp_valid,
    output logic [DW-1:0]              resp_data,
    output logic                       mem_rd,
    output logic [AW-1:0]              mem_read_adr,
    output logic                       mem_wr,
    output logic [AW-1:0]              mem_write_adr,
    output logic [DW-1:0]              mem_data_in,
    input  logic [DW-1:0]              mem_data_out,
    output logic [$clog2(DEPTH):0]     sb_count,
    output logic                       idle
);

    localparam int CW = $clog2(DEPTH) + 1;
    // A one-entry buffer still needs a (constant) 1-bit pointer.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [AW-1:0] buf_adr  [DEPTH];
    logic [DW-1:0] buf_data [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          resp_q;

    logic          st_acc;
    logic          ld_acc;
    logic          drain;
    logic          hit;
    logic [DW-1:0] fwd_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign req_ready = !rst && (count < CW'(DEPTH));
    assign st_acc    = req_valid && req_ready && req_we;
    assign ld_acc    = req_valid && req_ready && !req_we;
    assign drain     = !rst && (count != '0);

    // Walk from oldest to youngest so the last match wins. The head entry
    // is included even when it is being drained this cycle, which is what
    // keeps a read and a write to the same address from ever overlapping.
    always_comb begin
        logic [PW-1:0] idx;
        hit      = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (buf_adr[idx] == req_adr)) begin
                hit      = 1'b1;
                fwd_data = buf_data[idx];
            end
        end
    end

    assign mem_wr        = drain;
    assign mem_write_adr = drain ? buf_adr[head]  : '0;
    assign mem_data_in   = drain ? buf_data[head] : '0;
    assign mem_rd        = ld_acc && !hit;
    assign mem_read_adr  = mem_rd ? req_adr : '0;

    // Gating with rst suppresses the response of a load accepted just before reset.
    assign resp_valid = resp_q && !rst;
    assign sb_count   = count;
    assign idle       = (count == '0) && !resp_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            resp_q    <= 1'b0;
            resp_data <= '0;
        end else begin
            if (st_acc) begin
                buf_adr[tail]  <= req_adr;
                buf_data[tail] <= req_data;
                tail           <= ptr_inc(tail);
            end
            if (drain) begin
                head <= ptr_inc(head);
            end
            case ({st_acc, drain})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            resp_q <= ld_acc;
            if (ld_acc) begin
                resp_data <= hit ? fwd_data : mem_data_out;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int DEPTH = 4;
    localparam int AW    = 10;
    localparam int DW    = 64;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_adr;
    logic [DW-1:0] req_data;
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic          mem_rd;
    logic [AW-1:0] mem_read_adr;
    logic          mem_wr;
    logic [AW-1:0] mem_write_adr;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;
    logic [CW-1:0] sb_count;
    logic          idle;

    mem_access_unit #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_adr       (req_adr),
        .req_data      (req_data),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .mem_rd        (mem_rd),
        .mem_read_adr  (mem_read_adr),
        .mem_wr        (mem_wr),
        .mem_write_adr (mem_write_adr),
        .mem_data_in   (mem_data_in),
        .mem_data_out  (mem_data_out),
        .sb_count      (sb_count),
        .idle          (idle)
    );

    always #5 clk = ~clk;

    // Data memory attached to the DUT.
    logic [DW-1:0] mem [2**AW];
    assign mem_data_out = mem[mem_read_adr];
    always @(posedge clk) if (mem_wr) mem[mem_write_adr] <= mem_data_in;

    // Reference model: pending stores in acceptance order plus expected memory.
    typedef struct {
        logic [AW-1:0] adr;
        logic [DW-1:0] data;
    } ent_t;
    ent_t          ref_q[$];
    logic [DW-1:0] ref_mem [2**AW];
    logic          ref_resp_pend;
    logic [DW-1:0] ref_resp_data;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [DW-1:0] init_val(input int a);
        return DW'(a) * 64'h0101_0001 + 64'h77;
    endfunction

    // One clock cycle: drive at negedge, check outputs just after, update model.
    task automatic step(input logic r, input logic v, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic          exp_ready, exp_wr, acc, hit;
        logic [AW-1:0] exp_wadr;
        logic [DW-1:0] exp_wdata, result;
        @(negedge clk);
        rst = r; req_valid = v; req_we = we; req_adr = a; req_data = d;
        #1;
        if (r) begin
            chk("rst_ready", req_ready, 1'b0);
            chk("rst_mem_wr", mem_wr, 1'b0);
            chk("rst_mem_rd", mem_rd, 1'b0);
            chk("rst_resp_valid", resp_valid, 1'b0);
            ref_q.delete();
            ref_resp_pend = 1'b0;
            ref_resp_data = '0;
            return;
        end
        exp_ready = ref_q.size() < DEPTH;
        exp_wr    = ref_q.size() > 0;
        exp_wadr  = exp_wr ? ref_q[0].adr  : '0;
        exp_wdata = exp_wr ? ref_q[0].data : '0;
        acc       = v && exp_ready;
        hit       = 1'b0;
        result    = '0;
        if (acc && !we) begin
            for (int i = ref_q.size() - 1; i >= 0; i--) begin
                if (!hit && ref_q[i].adr == a) begin
                    hit    = 1'b1;
                    result = ref_q[i].data;
                end
            end
            if (!hit) result = ref_mem[a];
        end
        chk("req_ready", req_ready, exp_ready);
        chk("sb_count", sb_count, CW'(ref_q.size()));
        chk("mem_wr", mem_wr, exp_wr);
        chk("mem_write_adr", mem_write_adr, exp_wadr);
        chk("mem_data_in", mem_data_in, exp_wdata);
        chk("mem_rd", mem_rd, acc && !we && !hit);
        chk("mem_read_adr", mem_read_adr, (acc && !we && !hit) ? a : '0);
        chk("resp_valid", resp_valid, ref_resp_pend);
        chk("resp_data", resp_data, ref_resp_data);
        chk("idle", idle, (ref_q.size() == 0) && !ref_resp_pend);
        chk("rd_wr_overlap", mem_rd && mem_wr && (mem_read_adr == mem_write_adr), 1'b0);
        if (exp_wr) begin
            ref_mem[ref_q[0].adr] = ref_q[0].data;
            void'(ref_q.pop_front());
        end
        if (acc && we) ref_q.push_back('{adr: a, data: d});
        ref_resp_pend = acc && !we;
        if (acc && !we) ref_resp_data = result;
    endtask

    task automatic idle_cycle();
        step(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        int nbad;
        for (int i = 0; i < 2**AW; i++) begin
            mem[i]     = init_val(i);
            ref_mem[i] = init_val(i);
        end
        ref_resp_pend = 1'b0;
        ref_resp_data = '0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_data = '0;

        step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 1'b1, 10'd1, 64'h5);
        chk("reset_count", sb_count, '0);

        // Store 0xAA@5 then idle; written one cycle after accept.
        step(1'b0, 1'b1, 1'b1, 10'd5, 64'hAA);
        idle_cycle();
        chk("store_wadr", mem_write_adr, 10'd5);
        chk("store_wdata", mem_data_in, 64'hAA);
        idle_cycle();
        idle_cycle();
        chk("store_idle", idle, 1'b1);
        chk("store_mem", mem[5], 64'hAA);

        // Load from memory with empty buffer.
        mem[7] = 64'h1234; ref_mem[7] = 64'h1234;
        step(1'b0, 1'b1, 1'b0, 10'd7, '0);
        chk("load_rd_adr", mem_read_adr, 10'd7);
        idle_cycle();
        chk("load_resp", resp_data, 64'h1234);
        idle_cycle();
        chk("load_resp_once", resp_valid, 1'b0);

        // Two stores to the same address, then load: youngest forwarded.
        step(1'b0, 1'b1, 1'b1, 10'd3, 64'h11);
        step(1'b0, 1'b1, 1'b1, 10'd3, 64'h22);
        step(1'b0, 1'b1, 1'b0, 10'd3, '0);
        chk("fwd_no_rd", mem_rd, 1'b0);
        idle_cycle();
        chk("fwd_youngest", resp_data, 64'h22);
        idle_cycle();
        chk("fwd_mem", mem[3], 64'h22);

        // Load hits the head entry while it drains.
        step(1'b0, 1'b1, 1'b1, 10'd9, 64'h99);
        step(1'b0, 1'b1, 1'b0, 10'd9, '0);
        chk("head_fwd_wr", mem_wr, 1'b1);
        idle_cycle();
        chk("head_fwd_data", resp_data, 64'h99);

        // Five stores back to back, then back-to-back loads.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, AW'(40 + i), DW'(64'hC0 + i));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, AW'(40 + i), '0);
        idle_cycle();

        // Reset with stores outstanding: the undrained one is discarded.
        step(1'b0, 1'b1, 1'b1, 10'd20, 64'hE0);
        step(1'b0, 1'b1, 1'b1, 10'd21, 64'hE1);
        step(1'b0, 1'b1, 1'b1, 10'd22, 64'hE2);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        idle_cycle();
        chk("rst_discard_cnt", sb_count, '0);
        idle_cycle();
        chk("rst_discard_mem", mem[22], init_val(22));

        // Load accepted right before reset yields no response.
        step(1'b0, 1'b1, 1'b0, 10'd7, '0);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        idle_cycle();

        // Randomized traffic over a small address window to provoke hits.
        for (int n = 0; n < 10000; n++) begin
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                 {$urandom, $urandom});
        end
        for (int n = 0; n < 4; n++) idle_cycle();

        nbad = 0;
        for (int i = 0; i < 2**AW; i++) if (mem[i] !== ref_mem[i]) nbad++;
        chk("mem_final", DW'(nbad), '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
